ps2_scancode_decoder: RTL and testbench
=======================================

// Module: ps2_scancode_decoder
// PURPOSE
//   Parametrised PS/2 Set-2 scan-code decoder that supersedes the single-purpose F0 break flag.
//   Consumes bytes from the PS/2 receiver (rx_done_tick + rx_data) and tracks E0 (extended)
//   and F0 (break) prefixes. Emits complete make/break events into an internal FWFT FIFO.
//   Sits between the PS/2 receiver and the keyboard consumer logic.
// PARAMETERS
//   BREAK_CODE     8'hF0  break prefix byte
//   EXT_CODE       8'hE0  extended prefix byte
//   FIFO_DEPTH     4      event FIFO depth; power of 2, >=2
//   TIMEOUT_CYCLES 0      prefix timeout in clk cycles; 0 = disabled; max 2^24-1
// PORTS
//   clk          in   1               system clock; all logic on posedge
//   reset        in   1               synchronous, active-high
//   rx_done_tick in   1               one-cycle strobe, rx_data valid
//   rx_data      in   8               received byte
//   evt_ready    in   1               consumer pops head when evt_valid & evt_ready
//   clear_err    in   1               clears sticky overflow/proto_err
//   evt_valid    out  1               FIFO not empty
//   evt_code     out  8               head event key code (prefixes stripped)
//   evt_ext      out  1               head event was E0-prefixed
//   evt_break    out  1               head event is a release (F0-prefixed)
//   fifo_count   out  $clog2(D)+1     events stored
//   break_flag   out  1               high while a break prefix is pending (BRK/EXT_BRK)
//   overflow     out  1               sticky: event dropped, FIFO full
//   proto_err    out  1               sticky: illegal prefix sequence or byte 00/FF
//   timeout_tick out  1               one-cycle pulse when prefix state is abandoned
// BEHAVIOUR
//   Reset: FSM=IDLE, FIFO empty, timeout counter 0, every output 0.
//   reset wins over all inputs in the same cycle. Reset mid-sequence discards pending prefixes.
//   FSM advances only on cycles with rx_done_tick=1 (timeout excepted). P = BREAK_CODE or EXT_CODE.
//     IDLE:    EXT_CODE->EXT; BREAK_CODE->BRK; other->push {code,ext=0,brk=0}, stay.
//     EXT:     BREAK_CODE->EXT_BRK; EXT_CODE->stay EXT; other->push {code,1,0}, ->IDLE.
//     BRK:     any P->set proto_err, ->IDLE, no push; other->push {code,0,1}, ->IDLE.
//     EXT_BRK: any P->set proto_err, ->IDLE, no push; other->push {code,1,1}, ->IDLE.
//   Bytes 8'h00 and 8'hFF (key-detect error/overrun) in any state:
//     set proto_err, ->IDLE, no push.
//   break_flag = (state==BRK)|(state==EXT_BRK); registered, so it rises the cycle after F0 arrives.
//   Timeout (TIMEOUT_CYCLES>0): counter clears on each rx_done_tick and while in IDLE.
//     Counter increments every cycle in a non-IDLE state.
//     When it reaches TIMEOUT_CYCLES: ->IDLE, timeout_tick=1 for one cycle, counter clears.
//     A simultaneous rx_done_tick takes priority over the timeout.
//   FIFO: first-word-fall-through. A push on cycle N makes evt_valid=1 and the head fields valid on N+1.
//     Push while full and no pop: event dropped, overflow=1.
//     Push and pop while full: both occur, count unchanged, no overflow.
//     Pop while empty: ignored.
//     Pointers wrap modulo FIFO_DEPTH.
//   clear_err=1 clears overflow/proto_err next cycle. A set event in the same cycle wins (flag stays 1).
//   rx_done_tick is assumed single-cycle; back-to-back ticks on consecutive cycles are each processed.
// TESTING
//   1C -> one event {1C,ext0,brk0}. F0,1C -> break_flag=1 between bytes, then event {1C,0,1}.
//     evt_valid 1 cycle after last tick.
//   E0,75 -> {75,1,0}. E0,F0,75 -> {75,1,1}. E0,E0,6B -> {6B,1,0}, no error.
//   F0,E0 -> proto_err=1, no event, FSM IDLE. Then clear_err -> proto_err=0. Byte FF -> proto_err=1.
//   DEPTH=4, evt_ready=0, 5 make codes -> fifo_count=4, overflow=1, head = first code.
//     Then evt_ready=1 with a simultaneous push -> count stays 4.
//   TIMEOUT_CYCLES=100: F0 then idle 100 cycles -> timeout_tick pulse, break_flag=0.
//     Next byte 1C -> make event {1C,0,0}.
//   Assert reset after E0,F0 -> next byte 1C yields make {1C,0,0}. All outputs 0 during reset.

Source files
------------

// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scan-code decoder: folds E0/F0 prefixes into make/break events
// and queues them in a first-word-fall-through FIFO for the keyboard consumer.
module ps2_scancode_decoder #(
  parameter logic [7:0] BREAK_CODE     = 8'hF0,
  parameter logic [7:0] EXT_CODE       = 8'hE0,
  parameter int         FIFO_DEPTH     = 4,
  parameter int         TIMEOUT_CYCLES = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx_done_tick,
  input  logic [7:0]                    rx_data,
  input  logic                          evt_ready,
  input  logic                          clear_err,
  output logic                          evt_valid,
  output logic [7:0]                    evt_code,
  output logic                          evt_ext,
  output logic                          evt_break,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          break_flag,
  output logic                          overflow,
  output logic                          proto_err,
  output logic                          timeout_tick
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C   = (AW+1)'(FIFO_DEPTH);
  localparam logic        TO_EN     = (TIMEOUT_CYCLES > 0);
  localparam int          TO_LAST_I = (TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0;
  localparam logic [23:0] TO_LAST   = 24'(TO_LAST_I);

  // Bit 1 of the encoding marks a pending break prefix, bit 0 an extended prefix.
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_EXT     = 2'd1;
  localparam logic [1:0] S_BRK     = 2'd2;
  localparam logic [1:0] S_EXT_BRK = 2'd3;

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic          w_push;
  logic          w_push_ext;
  logic          w_push_brk;
  logic          w_err_set;
  logic          w_to_fire;
  logic          w_bad_byte;
  logic          w_is_prefix;
  logic [23:0]   r_to_cnt;
  logic          r_timeout_tick;

  logic [9:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_full;
  logic          w_pop;
  logic          w_wr;
  logic          w_ovf_set;
  logic          r_overflow;
  logic          r_proto_err;

  assign w_bad_byte  = (rx_data == 8'h00) | (rx_data == 8'hFF);
  assign w_is_prefix = (rx_data == BREAK_CODE) | (rx_data == EXT_CODE);

  // Prefix tracking: decides next state, event push and protocol errors.
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_push_ext  = 1'b0;
    w_push_brk  = 1'b0;
    w_err_set   = 1'b0;
    w_to_fire   = 1'b0;
    if (rx_done_tick) begin
      if (w_bad_byte) begin
        w_err_set   = 1'b1;
        w_state_nxt = S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (rx_data == EXT_CODE) begin
              w_state_nxt = S_EXT;
            end else if (rx_data == BREAK_CODE) begin
              w_state_nxt = S_BRK;
            end else begin
              w_push      = 1'b1;
              w_state_nxt = S_IDLE;
            end
          end
          S_EXT: begin
            if (rx_data == BREAK_CODE) begin
              w_state_nxt = S_EXT_BRK;
            end else if (rx_data == EXT_CODE) begin
              w_state_nxt = S_EXT;
            end else begin
              w_push      = 1'b1;
              w_push_ext  = 1'b1;
              w_state_nxt = S_IDLE;
            end
          end
          S_BRK, S_EXT_BRK: begin
            w_state_nxt = S_IDLE;
            if (w_is_prefix) begin
              w_err_set = 1'b1;
            end else begin
              w_push     = 1'b1;
              w_push_ext = r_state[0];
              w_push_brk = 1'b1;
            end
          end
          default: begin
            w_state_nxt = S_IDLE;
          end
        endcase
      end
    end else if (TO_EN && (r_state != S_IDLE) && (r_to_cnt == TO_LAST)) begin
      w_to_fire   = 1'b1;
      w_state_nxt = S_IDLE;
    end else begin
      w_state_nxt = r_state;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Prefix timeout counter; any received byte restarts the wait.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_to_cnt       <= 24'd0;
      r_timeout_tick <= 1'b0;
    end else begin
      r_timeout_tick <= w_to_fire;
      if (!TO_EN || rx_done_tick || (r_state == S_IDLE) || w_to_fire) begin
        r_to_cnt <= 24'd0;
      end else begin
        r_to_cnt <= r_to_cnt + 24'd1;
      end
    end
  end

  assign w_full    = (r_count == DEPTH_C);
  assign w_pop     = evt_ready & (r_count != '0);
  assign w_wr      = w_push & (~w_full | w_pop);
  assign w_ovf_set = w_push & w_full & ~w_pop;

  // Event storage, entries are {ext, brk, code}.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= 10'd0;
      end
    end else if (w_wr) begin
      r_mem[r_wr_ptr] <= {w_push_ext, w_push_brk, rx_data};
    end else begin
      r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
    end
  end

  // FIFO pointers and occupancy; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky error flags; a new set event beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end else if (clear_err) begin
        r_overflow <= 1'b0;
      end else begin
        r_overflow <= r_overflow;
      end
      if (w_err_set) begin
        r_proto_err <= 1'b1;
      end else if (clear_err) begin
        r_proto_err <= 1'b0;
      end else begin
        r_proto_err <= r_proto_err;
      end
    end
  end

  assign evt_valid    = (r_count != '0);
  assign evt_code     = r_mem[r_rd_ptr][7:0];
  assign evt_break    = r_mem[r_rd_ptr][8];
  assign evt_ext      = r_mem[r_rd_ptr][9];
  assign fifo_count   = r_count;
  assign break_flag   = r_state[1];
  assign overflow     = r_overflow;
  assign proto_err    = r_proto_err;
  assign timeout_tick = r_timeout_tick;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Bench for ps2_scancode_decoder: directed scan-code scenarios followed by random
// byte streams, every cycle compared against a queue-based reference model.
module tb_ps2_scancode_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_done_tick;
  logic [7:0] rx_data;
  logic       evt_ready;
  logic       clear_err;
  logic       evt_valid;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;
  logic [2:0] fifo_count;
  logic       break_flag;
  logic       overflow;
  logic       proto_err;
  logic       timeout_tick;

  int tests = 0;
  int fails = 0;

  // reference model state
  logic [9:0] mq[$];
  bit         m_ext, m_brk, m_ovf, m_perr, m_to;
  int         m_quiet;
  bit         rdy_def;

  ps2_scancode_decoder #(
    .BREAK_CODE(8'hF0), .EXT_CODE(8'hE0), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
    .evt_ready(evt_ready), .clear_err(clear_err), .evt_valid(evt_valid),
    .evt_code(evt_code), .evt_ext(evt_ext), .evt_break(evt_break),
    .fifo_count(fifo_count), .break_flag(break_flag), .overflow(overflow),
    .proto_err(proto_err), .timeout_tick(timeout_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit t, input logic [7:0] d, input bit rdy, input bit clr, input bit rst);
    bit         pop, push, set_err, set_ovf, fire;
    logic [9:0] ev;
    if (rst) begin
      mq.delete();
      m_ext = 0; m_brk = 0; m_ovf = 0; m_perr = 0; m_to = 0; m_quiet = 0;
      return;
    end
    pop = rdy && (mq.size() > 0);
    push = 0; set_err = 0; set_ovf = 0; fire = 0; ev = '0;
    if (t) begin
      m_quiet = 0;
      if (d == 8'h00 || d == 8'hFF) begin
        set_err = 1; m_ext = 0; m_brk = 0;
      end else if (m_brk) begin
        if (d == 8'hF0 || d == 8'hE0) set_err = 1;
        else begin push = 1; ev = {m_ext, 1'b1, d}; end
        m_ext = 0; m_brk = 0;
      end else if (d == 8'hF0) begin
        m_brk = 1;
      end else if (d == 8'hE0) begin
        m_ext = 1;
      end else begin
        push = 1; ev = {m_ext, 1'b0, d}; m_ext = 0;
      end
    end else if (m_ext || m_brk) begin
      m_quiet++;
      if (m_quiet == 100) begin
        fire = 1; m_ext = 0; m_brk = 0; m_quiet = 0;
      end
    end else begin
      m_quiet = 0;
    end
    if (push && mq.size() == 4 && !pop) set_ovf = 1;
    if (pop) void'(mq.pop_front());
    if (push && !set_ovf) mq.push_back(ev);
    m_perr = set_err ? 1'b1 : (clr ? 1'b0 : m_perr);
    m_ovf  = set_ovf ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_to   = fire;
  endtask

  task automatic cycle(input bit t, input logic [7:0] d, input bit rdy, input bit clr, input bit rst);
    reset = rst; rx_done_tick = t; rx_data = d; evt_ready = rdy; clear_err = clr;
    model_step(t, d, rdy, clr, rst);
    @(posedge clk); #1;
    chk("evt_valid", {31'd0, evt_valid}, {31'd0, mq.size() > 0});
    chk("fifo_count", {29'd0, fifo_count}, mq.size());
    chk("break_flag", {31'd0, break_flag}, {31'd0, m_brk});
    chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    chk("proto_err", {31'd0, proto_err}, {31'd0, m_perr});
    chk("timeout_tick", {31'd0, timeout_tick}, {31'd0, m_to});
    if (rst) begin
      chk("rst_head", {22'd0, evt_ext, evt_break, evt_code}, 32'd0);
    end else if (mq.size() > 0) begin
      chk("head", {22'd0, evt_ext, evt_break, evt_code}, {22'd0, mq[0]});
    end
  endtask

  task automatic send(input logic [7:0] d);
    cycle(1'b1, d, rdy_def, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, rdy_def, 1'b0, 1'b0);
  endtask

  task automatic drain_clear();
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    rdy_def = 1'b0;
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 8'hE0, 1'b1, 1'b1, 1'b1);

    send(8'h1C);
    chk("make_1C", {23'd0, evt_valid, evt_code}, {23'd0, 1'b1, 8'h1C});
    drain_clear();

    send(8'hF0);
    chk("brk_pending", {31'd0, break_flag}, 32'd1);
    send(8'h1C);
    chk("break_1C", {22'd0, evt_ext, evt_break, evt_code}, {22'd0, 2'b01, 8'h1C});
    drain_clear();

    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hE0); send(8'hE0); send(8'h6B);
    chk("ext_seq_count", {29'd0, fifo_count}, 32'd3);
    chk("ext_seq_err", {31'd0, proto_err}, 32'd0);
    drain_clear();

    send(8'hF0); send(8'hE0);
    chk("f0e0_err", {30'd0, proto_err, evt_valid}, 32'd2);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("err_cleared", {31'd0, proto_err}, 32'd0);
    send(8'hFF);
    chk("ff_err", {31'd0, proto_err}, 32'd1);
    drain_clear();

    for (int i = 0; i < 5; i++) send(8'h10 + 8'(i));
    chk("ovf_count", {29'd0, fifo_count}, 32'd4);
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
    chk("ovf_head", {24'd0, evt_code}, 32'h10);
    cycle(1'b1, 8'h22, 1'b1, 1'b0, 1'b0);
    chk("full_pushpop", {29'd0, fifo_count}, 32'd4);
    drain_clear();

    send(8'hF0);
    idle(100);
    chk("timeout", {30'd0, timeout_tick, break_flag}, 32'd2);
    send(8'h1C);
    chk("after_to", {22'd0, evt_ext, evt_break, evt_code}, {22'd0, 2'b00, 8'h1C});
    drain_clear();

    send(8'hE0); send(8'hF0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    send(8'h1C);
    chk("post_rst", {22'd0, evt_ext, evt_break, evt_code}, {22'd0, 2'b00, 8'h1C});
    drain_clear();

    for (int n = 0; n < 3000; n++) begin
      logic [7:0] d;
      int         sel;
      bit         t, rdy, clr, rst;
      sel = $urandom_range(0, 9);
      case (sel)
        0:       d = 8'h00;
        1:       d = 8'hFF;
        2, 3:    d = 8'hE0;
        4, 5:    d = 8'hF0;
        default: d = 8'($urandom_range(1, 254));
      endcase
      t   = ($urandom_range(0, 99) < 45);
      rdy = ($urandom_range(0, 3) != 0) ^ (n[9] == 1'b1);
      clr = ($urandom_range(0, 19) == 0);
      rst = ($urandom_range(0, 299) == 0);
      cycle(t, d, rdy, clr, rst);
      if ($urandom_range(0, 149) == 0) begin
        rdy_def = 1'b0;
        idle(105);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
